// File: rtl/usb_midi_audio_synth_pio_pkg.sv
// Shared definitions for the synth's Avalon-MM PIO blocks: register offsets,
// edge-capture mode encodings and the edge qualification helper.
package usb_midi_audio_synth_pio_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_RSVD    = 2'd1;
  localparam logic [1:0] REG_IRQMASK = 2'd2;
  localparam logic [1:0] REG_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Decides whether a debounced transition to new_level counts as a captured edge.
  function automatic logic edge_qualify(input int edge_type, input logic new_level);
    logic hit;
    case (edge_type)
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      default:   hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/usb_midi_audio_synth_debounce_bit.sv
// One button input: two-flop synchroniser, stability counter and debounced flop.
// update is high in the cycle whose clock edge flips db.
module usb_midi_audio_synth_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic db,
  output logic update
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          db_reg;
  logic [CW-1:0] cnt_reg;

  assign update = (s2_reg != db_reg) && (cnt_reg == CNT_LAST);
  assign db     = db_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg  <= IDLE_LEVEL;
      s2_reg  <= IDLE_LEVEL;
      db_reg  <= IDLE_LEVEL;
      cnt_reg <= '0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
      // Any cycle where the synchronised level agrees with db restarts the count.
      if (s2_reg == db_reg) begin
        cnt_reg <= '0;
      end else if (update) begin
        db_reg  <= s2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/usb_midi_audio_synth_key_pio.sv
// Push-button input PIO: debounced DATA, IRQ mask, write-1-to-clear edge capture
// and a level interrupt, on a zero-wait-state Avalon-MM slave.
module usb_midi_audio_synth_key_pio
  import usb_midi_audio_synth_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] db_vec;
  logic [WIDTH-1:0] upd_vec;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] irqmask_reg, irqmask_next;
  logic [WIDTH-1:0] edgecap_reg, edgecap_next;
  logic [WIDTH-1:0] wr_bits;
  logic             wr_en;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      usb_midi_audio_synth_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (IDLE_LEVEL[gi])
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[gi]),
        .db     (db_vec[gi]),
        .update (upd_vec[gi])
      );
      // An update always flips db, so the new level is the inverse of the current one.
      assign edge_evt[gi] = upd_vec[gi] & edge_qualify(EDGE_TYPE, ~db_vec[gi]);
    end
  endgenerate

  always_comb begin
    irqmask_next = irqmask_reg;
    edgecap_next = edgecap_reg;
    if (wr_en && (address == REG_IRQMASK)) begin
      irqmask_next = wr_bits;
    end
    if (wr_en && (address == REG_EDGECAP)) begin
      edgecap_next = edgecap_reg & ~wr_bits;
    end
    // A new edge overrides a simultaneous clear of the same bit.
    edgecap_next = edgecap_next | edge_evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_reg <= '0;
      edgecap_reg <= '0;
    end else begin
      irqmask_reg <= irqmask_next;
      edgecap_reg <= edgecap_next;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:    readdata[WIDTH-1:0] = db_vec;
      REG_IRQMASK: readdata[WIDTH-1:0] = irqmask_reg;
      REG_EDGECAP: readdata[WIDTH-1:0] = edgecap_reg;
      default:     readdata = '0;
    endcase
  end

  assign irq = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_usb_midi_audio_synth_key_pio.sv
// Scoreboard bench for the key PIO: directed scenarios with fixed expectations,
// then random button/bus traffic checked against a sample-window reference model.
module tb_usb_midi_audio_synth_key_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = 4'hF;
  logic        irq;

  usb_midi_audio_synth_key_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    logic        irq;
  } exp_t;
  exp_t sb[$];

  // Reference model: raw samples per clock edge, newest at index 0.
  logic [W-1:0] hist [0:D+1];
  logic [W-1:0] m_db, m_cap, m_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= D + 1; j++) hist[j] = 4'hF;
    m_db = 4'hF;
    m_cap = '0;
    m_mask = '0;
  endtask

  // A bit's debounced value flips once the synchronised input (two edges behind
  // the raw samples) has disagreed with it for D consecutive edges.
  task automatic model_step();
    logic [W-1:0] ev;
    logic all_diff;
    ev = '0;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[i] = ~m_db[i];
        if (m_db[i] == 1'b0) ev[i] = 1'b1;
      end
    end
    if (chipselect && !write_n) begin
      if (address == 2'd2) m_mask = writedata[W-1:0];
      if (address == 2'd3) m_cap = m_cap & ~writedata[W-1:0];
    end
    m_cap = m_cap | ev;
    for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = in_port;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_db};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Monitor: every read cycle the DUT presents is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && chipselect && write_n) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got read at addr %0d, expected no read", address);
        end else begin
          e = sb.pop_front();
          $display("rd addr=%0d data=0x%0h irq=%0b (exp 0x%0h/%0b)", e.addr, readdata, irq, e.data, e.irq);
          check($sformatf("rd_addr%0d", e.addr), readdata, e.data);
          check("irq", {31'd0, irq}, {31'd0, e.irq});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_c(input logic [1:0] a, input logic [31:0] d, input logic q);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    sb.push_back('{addr: a, data: d, irq: q});
    tick();
    chipselect = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    rd_c(a, model_read(a), |(m_cap & m_mask));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    $display("wr addr=%0d data=0x%0h", a, d);
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset: no edges, no interrupt.
    for (int n = 0; n < 10; n++) begin
      rd_c(2'd0, 32'hF, 1'b0);
      rd_c(2'd3, 32'h0, 1'b0);
    end

    // Falling edge on bit 0 with exact latency.
    wr(2'd2, 32'h1);
    rd_c(2'd2, 32'h1, 1'b0);
    in_port = 4'hE;
    repeat (6) rd_c(2'd0, 32'hF, 1'b0);
    rd_c(2'd0, 32'hE, 1'b1);
    rd_c(2'd3, 32'h1, 1'b1);

    // Short glitch on bit 2 is filtered out.
    in_port = 4'hA;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (8) tick();
    rd_c(2'd0, 32'hE, 1'b1);
    rd_c(2'd3, 32'h1, 1'b1);

    // Clear and new falling edge on bit 0 land on the same edge: set wins.
    in_port = 4'hF;
    repeat (10) tick();
    rd_c(2'd0, 32'hF, 1'b1);
    in_port = 4'hE;
    repeat (5) tick();
    wr(2'd3, 32'h1);
    rd_c(2'd3, 32'h1, 1'b1);
    rd_c(2'd0, 32'hE, 1'b1);

    // Masking, then unmask, then clear.
    wr(2'd2, 32'h0);
    rd_c(2'd3, 32'h1, 1'b0);
    in_port = 4'hC;
    repeat (8) tick();
    rd_c(2'd3, 32'h3, 1'b0);
    wr(2'd2, 32'h2);
    rd_c(2'd2, 32'h2, 1'b1);
    wr(2'd3, 32'h2);
    rd_c(2'd3, 32'h1, 1'b0);

    // Re-capture bit 1 so EDGECAP=0x3, then reset in the middle of a debounce.
    in_port = 4'hE;
    repeat (8) tick();
    in_port = 4'hC;
    repeat (8) tick();
    wr(2'd2, 32'h3);
    rd_c(2'd3, 32'h3, 1'b1);
    in_port = 4'h8;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    #1;
    $display("async reset: data=0x%0h irq=%0b", readdata, irq);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_data", readdata, 32'hF);
    chipselect = 1'b0;
    in_port = 4'hF;
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd_c(2'd3, 32'h0, 1'b0);
    rd_c(2'd2, 32'h0, 1'b0);
    rd_c(2'd0, 32'hF, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          in_port = in_port ^ 4'($urandom_range(1, 15));
          repeat ($urandom_range(1, 7)) tick();
        end
        4, 5, 6: rd(2'($urandom_range(0, 3)));
        7:       wr(2'd2, $urandom);
        8:       wr(2'd3, $urandom);
        default: wr(2'($urandom_range(0, 1)), $urandom);
      endcase
    end
    for (int a = 0; a < 4; a++) rd(2'(a));

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
